block_emitter: RTL and testbench

Character-stream generator that drives the BlockChecker input. It accepts keyword commands over a valid/ready handshake and serialises them as 8-bit ASCII characters, one per clock, with a single space after each word. It also tracks begin/end nesting, so benches and top-level tests get the `result` value BlockChecker is expected to report.

---
 rtl/block_emitter.sv | 214 +++++++++++++++++++++
 tb/tb_block_emitter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_emitter.sv
// block_emitter: turns BEGIN/END/NEAR/SPACE commands into a space-separated ASCII stream
// and tracks begin/end nesting. Define BLOCK_EMITTER_MIXCASE_EN for alternating letter case.
module block_emitter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               underflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_SEP
  } state_t;

  localparam logic [1:0]         CMD_BEGIN   = 2'd0;
  localparam logic [1:0]         CMD_END     = 2'd1;
  localparam logic [1:0]         CMD_NEAR    = 2'd2;
  localparam logic [1:0]         CMD_SPACE   = 2'd3;
  localparam logic [7:0]         ASCII_SPACE = 8'h20;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX   = '1;

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_cmd;
  logic [2:0]         r_idx;
  logic [7:0]         r_out;
  logic               r_out_valid;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_balanced;
  logic               r_underflow;

  logic               w_accept;
  logic [2:0]         w_word_len;
  logic               w_last_char;
  logic [7:0]         w_raw_char;
  logic [7:0]         w_letter;
  logic [1:0]         w_cmd_next;
  logic [2:0]         w_idx_next;
  logic [7:0]         w_out_next;
  logic               w_out_valid_next;
  logic [DEPTH_W-1:0] w_depth_next;
  logic               w_underflow_next;
  logic               w_balanced_next;

  // Lowercase character of each keyword; SPACE has no letters.
  function automatic logic [7:0] word_char(input logic [1:0] c, input logic [2:0] i);
    logic [7:0] ch;
    ch = ASCII_SPACE;
    case (c)
      CMD_BEGIN: begin
        case (i)
          3'd0:    ch = 8'h62;
          3'd1:    ch = 8'h65;
          3'd2:    ch = 8'h67;
          3'd3:    ch = 8'h69;
          3'd4:    ch = 8'h6E;
          default: ch = ASCII_SPACE;
        endcase
      end
      CMD_END: begin
        case (i)
          3'd0:    ch = 8'h65;
          3'd1:    ch = 8'h6E;
          3'd2:    ch = 8'h64;
          default: ch = ASCII_SPACE;
        endcase
      end
      CMD_NEAR: begin
        case (i)
          3'd0:    ch = 8'h62;
          3'd1:    ch = 8'h65;
          3'd2:    ch = 8'h67;
          default: ch = ASCII_SPACE;
        endcase
      end
      default: ch = ASCII_SPACE;
    endcase
    return ch;
  endfunction

  assign cmd_ready   = (r_state == S_IDLE) || (r_state == S_SEP);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_word_len  = (r_cmd == CMD_BEGIN) ? 3'd5 : 3'd3;
  assign w_last_char = (r_idx == (w_word_len - 3'd1));
  assign w_raw_char  = word_char(r_cmd, r_idx);

`ifdef BLOCK_EMITTER_MIXCASE_EN
  logic r_toggle;

  assign w_letter = r_toggle ? (w_raw_char - 8'h20) : w_raw_char;

  // Only letters flip the case; separator spaces leave it alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_toggle <= 1'b1;
    end else if (r_state == S_EMIT) begin
      r_toggle <= ~r_toggle;
    end
  end
`else
  assign w_letter = w_raw_char;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = (cmd == CMD_SPACE) ? S_SEP : S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_last_char) begin
          w_state_next = S_SEP;
        end
      end
      S_SEP: begin
        if (w_accept) begin
          w_state_next = (cmd == CMD_SPACE) ? S_SEP : S_EMIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered character, handshake capture and bookkeeping.
  always_comb begin
    w_out_next       = ASCII_SPACE;
    w_out_valid_next = 1'b0;
    w_cmd_next       = r_cmd;
    w_idx_next       = r_idx;
    w_depth_next     = r_depth;
    w_underflow_next = r_underflow;
    case (r_state)
      S_EMIT: begin
        w_out_next       = w_letter;
        w_out_valid_next = 1'b1;
        w_idx_next       = r_idx + 3'd1;
      end
      S_SEP: begin
        w_out_valid_next = 1'b1;
        // The word's trailing space is where its nesting effect lands.
        if (r_cmd == CMD_BEGIN) begin
          if (r_depth != DEPTH_MAX) begin
            w_depth_next = r_depth + DEPTH_W'(1);
          end
        end else if (r_cmd == CMD_END) begin
          if (r_depth != '0) begin
            w_depth_next = r_depth - DEPTH_W'(1);
          end else begin
            w_underflow_next = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (w_accept) begin
      w_cmd_next = cmd;
      w_idx_next = '0;
    end
    w_balanced_next = (w_depth_next == '0) && !w_underflow_next;
  end

  // Datapath registers; a low reset mid-word drops the partial word without touching depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cmd       <= CMD_BEGIN;
      r_idx       <= '0;
      r_out       <= ASCII_SPACE;
      r_out_valid <= 1'b0;
      r_depth     <= '0;
      r_balanced  <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_cmd       <= w_cmd_next;
      r_idx       <= w_idx_next;
      r_out       <= w_out_next;
      r_out_valid <= w_out_valid_next;
      r_depth     <= w_depth_next;
      r_balanced  <= w_balanced_next;
      r_underflow <= w_underflow_next;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign depth     = r_depth;
  assign balanced  = r_balanced;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_block_emitter.sv
// Bench for block_emitter: a character-queue model checked every cycle against two instances
// (DEPTH_W=8 and DEPTH_W=2), plus directed scenarios pinned to literal expectations.
module tb_block_emitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd;

  logic       rdy8, vld8, bal8, uf8;
  logic [7:0] out8, depth8;
  logic       rdy2, vld2, bal2, uf2;
  logic [7:0] out2;
  logic [1:0] depth2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  block_emitter #(.DEPTH_W(8)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(rdy8),
    .out(out8), .out_valid(vld8), .depth(depth8), .balanced(bal8), .underflow(uf8)
  );

  block_emitter #(.DEPTH_W(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(rdy2),
    .out(out2), .out_valid(vld2), .depth(depth2), .balanced(bal2), .underflow(uf2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: a queue of pending characters ----------------
  typedef struct {
    logic [7:0] ch;
    bit         sep;
    logic [1:0] code;
  } ent_t;

  ent_t       q[$];
  logic [7:0] m_out   = 8'h20;
  bit         m_vld   = 0;
  bit         m_ready = 1;
  int         m_depth8 = 0, m_depth2 = 0;
  bit         m_uf8 = 0, m_uf2 = 0;
`ifdef BLOCK_EMITTER_MIXCASE_EN
  bit         m_tog = 1;
`endif
  logic [7:0] seen[$];

  function automatic string word_of(input logic [1:0] c);
    case (c)
      2'd0:    return "begin";
      2'd1:    return "end";
      2'd2:    return "beg";
      default: return "";
    endcase
  endfunction

  task automatic book(input logic [1:0] c, inout int d, inout bit uf, input int maxd);
    if (c == 2'd0) begin
      if (d < maxd) d++;
    end else if (c == 2'd1) begin
      if (d > 0) d--;
      else uf = 1;
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_out = 8'h20; m_vld = 0;
      m_depth8 = 0; m_depth2 = 0; m_uf8 = 0; m_uf2 = 0;
`ifdef BLOCK_EMITTER_MIXCASE_EN
      m_tog = 1;
`endif
    end else begin
      bit    rdy;
      ent_t  e;
      string w;
      rdy = (q.size() <= 1);
      if (q.size() == 0) begin
        m_out = 8'h20; m_vld = 0;
      end else begin
        e = q.pop_front();
        m_vld = 1;
        if (e.sep) begin
          m_out = 8'h20;
          book(e.code, m_depth8, m_uf8, 255);
          book(e.code, m_depth2, m_uf2, 3);
        end else begin
`ifdef BLOCK_EMITTER_MIXCASE_EN
          m_out = m_tog ? e.ch - 8'h20 : e.ch;
          m_tog = !m_tog;
`else
          m_out = e.ch;
`endif
        end
      end
      if (cmd_valid && rdy) begin
        w = word_of(cmd);
        for (int i = 0; i < w.len(); i++) q.push_back('{ch: w[i], sep: 0, code: cmd});
        q.push_back('{ch: 8'h20, sep: 1, code: cmd});
      end
    end
    m_ready = (q.size() <= 1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out",        out8,   m_out);
      check("out_valid",  vld8,   m_vld);
      check("cmd_ready",  rdy8,   m_ready);
      check("depth",      depth8, m_depth8);
      check("underflow",  uf8,    m_uf8);
      check("balanced",   bal8,   (m_depth8 == 0) && !m_uf8);
      check("w2_out",     {vld2, out2}, {m_vld, m_out});
      check("w2_ready",   rdy2,   m_ready);
      check("w2_depth",   depth2, m_depth2);
      check("w2_underflow", uf2,  m_uf2);
      check("w2_balanced", bal2,  (m_depth2 == 0) && !m_uf2);
      if (vld8) seen.push_back(out8);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; cmd_valid = 1'b0;
    sync();
    reset = 1'b1;
    seen.delete();
  endtask

  task automatic send(input logic [1:0] c);
    bit acc;
    int n;
    cmd = c; cmd_valid = 1'b1; acc = 0; n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = rdy8;
      @(posedge clk);
      n++;
    end
    #1 cmd_valid = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  function automatic string seen_str();
    string s;
    s = "";
    foreach (seen[i]) s = {s, $sformatf("%c", seen[i])};
    return s;
  endfunction

`ifdef BLOCK_EMITTER_MIXCASE_EN
  localparam string EXP_BEGIN   = "BeGiN ";
  localparam string EXP_BEG_END = "BeGiN eNd ";
  localparam string EXP_END     = "EnD ";
  localparam string EXP_NEAR_SP = "BeG   ";
  localparam string EXP_ABORT   = "Be";
`else
  localparam string EXP_BEGIN   = "begin ";
  localparam string EXP_BEG_END = "begin end ";
  localparam string EXP_END     = "end ";
  localparam string EXP_NEAR_SP = "beg   ";
  localparam string EXP_ABORT   = "be";
`endif

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd = 2'd0;
    @(posedge clk); #1;
    chk_en = 1;

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_out", out8, 8'h20);
    check("rst_out_valid", vld8, 0);
    check("rst_cmd_ready", rdy8, 1);
    check("rst_depth", depth8, 0);
    check("rst_balanced", bal8, 1);
    check("rst_underflow", uf8, 0);
    sync();

    // Single BEGIN.
    do_reset();
    send(2'd0); idle(8);
    check_str("begin_chars", seen_str(), EXP_BEGIN);
    check("begin_depth", depth8, 1);
    check("begin_balanced", bal8, 0);

    // BEGIN then END back-to-back.
    do_reset();
    send(2'd0); send(2'd1); idle(6);
    check_str("begin_end_chars", seen_str(), EXP_BEG_END);
    check("begin_end_depth", depth8, 0);
    check("begin_end_balanced", bal8, 1);

    // END from reset underflows; balance never recovers.
    do_reset();
    send(2'd1); idle(6);
    check_str("end_chars", seen_str(), EXP_END);
    check("end_underflow", uf8, 1);
    check("end_depth", depth8, 0);
    check("end_balanced", bal8, 0);
    send(2'd0); send(2'd1); idle(8);
    check("after_uf_balanced", bal8, 0);
    check("after_uf_underflow", uf8, 1);

    // NEAR then two SPACEs.
    do_reset();
    send(2'd2); send(2'd3); send(2'd3); idle(6);
    check_str("near_space_chars", seen_str(), EXP_NEAR_SP);
    check("near_depth", depth8, 0);
    check("near_balanced", bal8, 1);

    // Reset low on the edge that would register BEGIN's third character.
    do_reset();
    send(2'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("abort_out", out8, 8'h20);
    check("abort_out_valid", vld8, 0);
    check("abort_depth", depth8, 0);
    check("abort_balanced", bal8, 1);
    check("abort_cmd_ready", rdy8, 1);
    check_str("abort_chars", seen_str(), EXP_ABORT);

    // Narrow counter saturates at 3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(2'd0); idle(7);
      check($sformatf("w2_sat_depth_%0d", i), depth2, (i < 3) ? i + 1 : 3);
      check($sformatf("w2_sat_balanced_%0d", i), bal2, 0);
    end

    // Randomised traffic; the per-cycle model check does the work.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit      rdy_s, pend;
      int unsigned r;
      @(negedge clk);
      rdy_s = rdy8;
      @(posedge clk); #1;
      pend = cmd_valid && !rdy_s;
      reset = ($urandom_range(0, 299) != 0);
      if (pend) begin
        if ($urandom_range(0, 9) == 0) cmd_valid = 1'b0;
      end else begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 99);
        cmd = (r < 40) ? 2'd0 : (r < 70) ? 2'd1 : (r < 85) ? 2'd2 : 2'd3;
      end
    end
    reset = 1'b1; cmd_valid = 1'b0;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
